// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its stall/flush sequencer.
// master : pipeline side. It drives the ID/EX/MEM hazard inputs and receives the register controls.
// slave  : sequencer side. It drives the en/flush pairs, pc_en, the stage valids, the counters and
//          mem_timeout.
// Ports  : id_rs1/id_rs2/id_use_rs1/id_use_rs2/id_fence, ex_rd/ex_memread/ex_redirect,
//          dmem_req/dmem_ready, pc_en, {ifid,idex,exmem,memwb}_{en,flush}, v_id..v_wb,
//          stall_cycles, flush_events, mem_timeout.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_fence;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_redirect;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic             v_id;
  logic             v_ex;
  logic             v_mem;
  logic             v_wb;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic             mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_fence,
           ex_rd, ex_memread, ex_redirect, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush,
           v_id, v_ex, v_mem, v_wb, stall_cycles, flush_events, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_fence,
           ex_rd, ex_memread, ex_redirect, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush,
           v_id, v_ex, v_mem, v_wb, stall_cycles, flush_events, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// It resolves data-memory wait states, EX redirects, FENCE drains and load-use hazards, in that
// priority order. It tracks stage valid bits, counts stall cycles and redirects with saturating
// counters, and raises a sticky memory-wait timeout.
// Ports: CLK (rising edge), RST (synchronous, active low), bus (slave side of the hazard bundle).
// The register controls on bus are combinational. The valids, counters and mem_timeout are
// registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN         = 2'd0,
    S_MEM_WAIT    = 2'd1,
    S_FENCE_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             v_id_q, v_id_d, v_ex_q, v_ex_d, v_mem_q, v_mem_d, v_wb_q, v_wb_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             tmo_q, tmo_d;

  logic mem_stall, redir, pipe_busy, fence_hold, rs_hit, load_use;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush;

  // Hazard detection
  always_comb begin
    mem_stall  = bus.dmem_req & ~bus.dmem_ready & v_mem_q;
    // A redirect is accepted only when memory is not holding the pipeline.
    redir      = bus.ex_redirect & v_ex_q & ~mem_stall;
    pipe_busy  = v_ex_q | v_mem_q | v_wb_q;
    fence_hold = ((state_q == S_FENCE_DRAIN) |
                  ((state_q == S_RUN) & bus.id_fence & v_id_q)) & pipe_busy;
    rs_hit     = (bus.id_use_rs1 & (bus.ex_rd == bus.id_rs1)) |
                 (bus.id_use_rs2 & (bus.ex_rd == bus.id_rs2));
    load_use   = bus.ex_memread & v_ex_q & (bus.ex_rd != 5'd0) & rs_hit & v_id_q;
  end

  // Register controls, highest-priority hazard first
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    memwb_flush = 1'b0;
    if (mem_stall) begin
      // Freeze everything up to MEM and send a bubble into WB.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (redir) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (fence_hold || load_use) begin
      // Hold the instruction in ID and insert a bubble into EX.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d = S_MEM_WAIT;
        end else if (!redir && fence_hold) begin
          state_d = S_FENCE_DRAIN;
        end
      end
      S_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = S_RUN;
        end
      end
      S_FENCE_DRAIN: begin
        // The fence advances into EX in the cycle the pipeline behind it is empty.
        if (!mem_stall && (redir || !pipe_busy)) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Valid bits, counters and watchdog. Flush takes priority over enable.
  always_comb begin
    v_id_d  = ifid_flush  ? 1'b0 : (ifid_en  ? 1'b1    : v_id_q);
    v_ex_d  = idex_flush  ? 1'b0 : (idex_en  ? v_id_q  : v_ex_q);
    v_mem_d = exmem_flush ? 1'b0 : (exmem_en ? v_ex_q  : v_mem_q);
    v_wb_d  = memwb_flush ? 1'b0 : (memwb_en ? v_mem_q : v_wb_q);

    stall_d = stall_q;
    if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    flush_d = flush_q;
    if (redir && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end

    wd_d = '0;
    if (state_q == S_MEM_WAIT) begin
      wd_d = (wd_q != {TO_W{1'b1}}) ? wd_q + TO_W'(1) : wd_q;
    end
    tmo_d = tmo_q | (wd_d >= TO_W'(TIMEOUT));
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_RUN;
      v_id_q  <= 1'b0;
      v_ex_q  <= 1'b0;
      v_mem_q <= 1'b0;
      v_wb_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v_id_q  <= v_id_d;
      v_ex_q  <= v_ex_d;
      v_mem_q <= v_mem_d;
      v_wb_q  <= v_wb_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_en     = exmem_en;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.memwb_en     = memwb_en;
  assign bus.memwb_flush  = memwb_flush;
  assign bus.v_id         = v_id_q;
  assign bus.v_ex         = v_ex_q;
  assign bus.v_mem        = v_mem_q;
  assign bus.v_wb         = v_wb_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;
  assign bus.mem_timeout  = tmo_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// The driver applies one cycle of stimulus after each rising edge. It predicts that cycle's
// outputs from a pipeline-occupancy model and queues them. The monitor compares on the falling
// edge.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW   = 6;
  localparam int unsigned TOW  = 3;
  localparam int unsigned TMO  = 4;
  localparam int          CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       fence;
    logic [4:0] ex_rd;
    logic       memread;
    logic       redir;
    logic       dreq;
    logic       drdy;
  } stim_t;

  typedef struct {
    logic [8:0] ctl;
    logic [3:0] vld;
    int         stalls;
    int         flushes;
    logic       tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CW), .TO_W(TOW), .TIMEOUT(TMO)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: which stages hold an instruction, plus the memory-wait and fence-drain conditions.
  bit m_id, m_ex, m_mem, m_wb;
  bit m_wait, m_drain, m_tmo;
  int m_waited, m_stalls, m_flushes;

  task automatic model_reset();
    m_id = 0; m_ex = 0; m_mem = 0; m_wb = 0;
    m_wait = 0; m_drain = 0; m_tmo = 0;
    m_waited = 0; m_stalls = 0; m_flushes = 0;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst     = ($urandom_range(0, 249) != 0);
    s.rs1     = 5'($urandom_range(0, 3));
    s.rs2     = 5'($urandom_range(0, 3));
    s.use1    = 1'($urandom_range(0, 1));
    s.use2    = 1'($urandom_range(0, 1));
    s.fence   = ($urandom_range(0, 11) == 0);
    s.ex_rd   = 5'($urandom_range(0, 3));
    s.memread = ($urandom_range(0, 2) == 0);
    s.redir   = ($urandom_range(0, 7) == 0);
    s.dreq    = ($urandom_range(0, 2) == 0);
    s.drdy    = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  // Drive one cycle, predict its outputs, advance the model across the next rising edge.
  task automatic cyc(input stim_t s);
    exp_t e;
    bit hold, redir, busy, fence, lu;
    bit n_id, n_ex, n_mem, n_wb;
    #1;
    rst_n          = s.rst;
    bus.id_rs1     = s.rs1;
    bus.id_rs2     = s.rs2;
    bus.id_use_rs1 = s.use1;
    bus.id_use_rs2 = s.use2;
    bus.id_fence   = s.fence;
    bus.ex_rd      = s.ex_rd;
    bus.ex_memread = s.memread;
    bus.ex_redirect = s.redir;
    bus.dmem_req   = s.dreq;
    bus.dmem_ready = s.drdy;

    e.vld     = {m_id, m_ex, m_mem, m_wb};
    e.stalls  = m_stalls;
    e.flushes = m_flushes;
    e.tmo     = m_tmo;

    busy  = m_ex || m_mem || m_wb;
    hold  = s.dreq && !s.drdy && m_mem;
    redir = !hold && s.redir && m_ex;
    fence = !hold && !redir && !m_wait && (m_drain || (s.fence && m_id)) && busy;
    lu    = !hold && !redir && !fence && s.memread && m_ex && m_id && (s.ex_rd != 0) &&
            ((s.use1 && s.rs1 == s.ex_rd) || (s.use2 && s.rs2 == s.ex_rd));

    // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
    if (hold) begin
      e.ctl = 9'b000000011;
      n_id = m_id; n_ex = m_ex; n_mem = m_mem; n_wb = 1'b0;
    end else if (redir) begin
      e.ctl = 9'b111111010;
      n_id = 1'b0; n_ex = 1'b0; n_mem = m_ex; n_wb = m_mem;
    end else if (fence || lu) begin
      e.ctl = 9'b000111010;
      n_id = m_id; n_ex = 1'b0; n_mem = m_ex; n_wb = m_mem;
    end else begin
      e.ctl = 9'b110101010;
      n_id = 1'b1; n_ex = m_id; n_mem = m_ex; n_wb = m_mem;
    end
    exp_q.push_back(e);

    if (!s.rst) begin
      model_reset();
    end else begin
      m_id = n_id; m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
      if (e.ctl[8] == 1'b0 && m_stalls < CMAX) m_stalls++;
      if (redir && m_flushes < CMAX) m_flushes++;
      if (m_wait) begin
        m_waited++;
        if (m_waited >= TMO) m_tmo = 1;
      end else begin
        m_waited = 0;
      end
      if (m_wait) m_wait = !s.drdy;
      else if (m_drain) m_drain = !(!hold && (redir || !busy));
      else if (hold) m_wait = 1;
      else m_drain = fence;
    end
    @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Monitor: the outputs are valid every cycle, so one expectation is consumed per falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ctl", 32'({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                      bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush}), 32'(e.ctl));
      chk("valid", 32'({bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}), 32'(e.vld));
      chk("stall_cycles", 32'(bus.stall_cycles), 32'(e.stalls));
      chk("flush_events", 32'(bus.flush_events), 32'(e.flushes));
      chk("mem_timeout", 32'(bus.mem_timeout), 32'(e.tmo));
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    s = idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_fence = 0; bus.ex_rd = '0; bus.ex_memread = 0; bus.ex_redirect = 0;
    bus.dmem_req = 0; bus.dmem_ready = 0;
    repeat (3) @(posedge clk);
    model_reset();

    // Fill the pipeline from empty.
    repeat (6) cyc(idle());

    // Load-use on rs2, then with x0 as destination.
    s = idle(); s.memread = 1; s.ex_rd = 5'd5; s.use2 = 1; s.rs2 = 5'd5;
    cyc(s); repeat (2) cyc(idle());
    s.ex_rd = 5'd0; s.rs2 = 5'd0;
    cyc(s); repeat (2) cyc(idle());

    // Redirect coinciding with a load-use hazard.
    s = idle(); s.memread = 1; s.ex_rd = 5'd7; s.use1 = 1; s.rs1 = 5'd7; s.redir = 1;
    cyc(s); repeat (4) cyc(idle());

    // Three memory wait cycles followed by the ready cycle.
    s = idle(); s.dreq = 1;
    repeat (3) cyc(s);
    s.drdy = 1; cyc(s);
    repeat (3) cyc(idle());

    // FENCE draining a full pipeline.
    s = idle(); s.fence = 1;
    repeat (4) cyc(s);
    repeat (4) cyc(idle());

    // Watchdog: long wait, ready, then only reset clears the error.
    s = idle(); s.dreq = 1;
    repeat (9) cyc(s);
    s.drdy = 1; cyc(s);
    repeat (3) cyc(idle());
    s = idle(); s.rst = 0; cyc(s);
    repeat (5) cyc(idle());

    // Randomised traffic.
    repeat (4000) cyc(rnd());
    repeat (2) cyc(idle());

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Generates the en/Flush pair for every pipeline register and pc_en, resolving load-use hazards, EX-stage redirects, data-memory wait states and FENCE drains.
- Tracks per-stage valid bits that mirror the pipeline registers, keeps performance counters, and raises a sticky memory-timeout error.

Parameters:
- CNT_W, 32, width of saturating performance counters
- TO_W, 8, width of memory-wait watchdog counter
- TIMEOUT, 200, MEM_WAIT cycles before mem_timeout sets (must be < 2^TO_W)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
- id_fence  in  1  ID holds FENCE/FENCE.I
- ex_rd  in  5  destination register in EX
- ex_memread  in  1  EX instruction is a load
- ex_redirect  in  1  branch taken / JAL / JALR resolved in EX
- dmem_req  in  1  MEM stage issues data-memory access
- dmem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC update enable
- ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush  out  1 each  pipeline register controls
- v_id, v_ex, v_mem, v_wb  out  1 each  stage valid bits
- stall_cycles  out  CNT_W  cycles with pc_en=0
- flush_events  out  CNT_W  cycles with ex_redirect accepted
- mem_timeout  out  1  sticky watchdog error

Behaviour:
- Reset is synchronous: while RST=0 at the clock edge, state goes to RUN, valid bits, counters and mem_timeout go to 0, and the watchdog clears.
- Control outputs are combinational from the current state and inputs (zero latency). Default: all en=1, all flush=0.
- States: RUN, MEM_WAIT, FENCE_DRAIN (2-bit encoding).
- mem_stall = dmem_req & ~dmem_ready & v_mem.
- load_use = ex_memread & v_ex & (ex_rd != 0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)) & v_id.
- Priority, highest first, in every state:
  1. mem_stall: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush=1.
  2. ex_redirect & v_ex: pc_en=1; ifid_flush=1; idex_flush=1.
  3. FENCE_DRAIN, or RUN with id_fence&v_id, while v_ex|v_mem|v_wb: pc_en=0; ifid_en=0; idex_flush=1.
  4. load_use: pc_en=0; ifid_en=0; idex_flush=1. Exactly 1 bubble.
- Flush dominates en on the same register.
- Transitions:
  - RUN→MEM_WAIT on mem_stall.
  - RUN→FENCE_DRAIN on id_fence&v_id, no mem_stall, no redirect, pipeline not empty.
  - MEM_WAIT→RUN on dmem_ready. If a fence was draining, re-evaluate as RUN next cycle.
  - FENCE_DRAIN→RUN when v_ex=v_mem=v_wb=0 (fence advances to EX that cycle) or on accepted redirect.
  - FENCE_DRAIN stays put under mem_stall.
- Valid bits update with the same en/flush as their register:
  - flush→0; en→upstream valid; else hold.
  - Upstream of v_id is constant 1 (fetch always valid after reset).
- Watchdog:
  - Increments each MEM_WAIT cycle; clears in any other state.
  - When it reaches TIMEOUT, mem_timeout=1, held until reset; pipeline stays frozen.
  - The watchdog counter saturates.
- Counters: saturate at all-ones and never wrap.
  - stall_cycles +1 per cycle pc_en=0.
  - flush_events +1 per accepted redirect.

Test Plan:
- Reset then release RST: cycle 0 all valid=0. After 4 free cycles v_id..v_wb=1111, all en=1, flush=0.
- Load x5 in EX (ex_memread=1, ex_rd=5), ID reads rs2=5: one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; stall_cycles=1.
- Same as above with ex_rd=0: no stall.
- ex_redirect=1 simultaneous with load_use: ifid_flush=idex_flush=1, pc_en=1; flush_events=1; stall_cycles unchanged.
- dmem_req=1, dmem_ready=0 for 3 cycles, then 1: exmem_en=0 and memwb_flush=1 for 3 cycles. State returns to RUN after the ready cycle; stall_cycles=3.
- id_fence with v_ex,v_mem,v_wb=1: 3 drain cycles (idex_flush=1), then the fence enters EX.
- TIMEOUT=4 with dmem_ready held 0: mem_timeout=1 on 5th MEM_WAIT cycle, stays 1 after dmem_ready, clears only on RST=0 edge.
